// File: rtl/snn_pkg.sv
// Shared types for the SNN output-layer blocks: classifier FSM states and
// winner codes reported to the host.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_N0   = 2'b01,
    WIN_N1   = 2'b10
  } winner_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the input once and pulses for one cycle
// while the live input is high and the registered copy is still low.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_d, d_q;

  always_comb d_d = d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/spike_rate_classifier.sv
// Counts output-layer spikes per neuron over a window of network time steps
// and reports both counts plus the more active neuron.
module spike_rate_classifier #(
  parameter int CNT_BITS = 8
) (
  input  logic                system_clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                delay_clk,
  input  logic [1:0]          output_spikes,
  input  logic [7:0]          window_len,
  output logic [CNT_BITS-1:0] count0,
  output logic [CNT_BITS-1:0] count1,
  output logic [1:0]          winner,
  output logic                result_valid,
  output logic                busy
);
  import snn_pkg::*;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic start, tick;

  rise_detect u_enable_rise (
    .clk   (system_clock),
    .rst   (reset),
    .d     (enable),
    .pulse (start)
  );

  rise_detect u_dclk_rise (
    .clk   (system_clock),
    .rst   (reset),
    .d     (delay_clk),
    .pulse (tick)
  );

  state_t                state_d, state_q;
  logic [7:0]            len_d, len_q;
  logic [7:0]            step_d, step_q;
  logic [CNT_BITS-1:0]   acc0_d, acc0_q;
  logic [CNT_BITS-1:0]   acc1_d, acc1_q;
  logic [CNT_BITS-1:0]   count0_d, count0_q;
  logic [CNT_BITS-1:0]   count1_d, count1_q;
  winner_t               winner_d, winner_q;
  logic                  valid_d, valid_q;
  logic                  busy_d, busy_q;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    step_d   = step_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    count0_d = count0_q;
    count1_d = count1_q;
    winner_d = winner_q;
    valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && window_len != 8'd0) begin
          state_d = ST_COUNT;
          len_d   = window_len;
          step_d  = 8'd0;
          acc0_d  = '0;
          acc1_d  = '0;
        end
      end

      ST_COUNT: begin
        if (start) begin
          // A restart discards the concurrent tick; a zero-length restart
          // abandons the window just as a zero-length start is ignored.
          state_d = (window_len != 8'd0) ? ST_COUNT : ST_IDLE;
          len_d   = window_len;
          step_d  = 8'd0;
          acc0_d  = '0;
          acc1_d  = '0;
        end else if (tick) begin
          if (output_spikes[0] && acc0_q != CNT_MAX) acc0_d = acc0_q + 1'b1;
          if (output_spikes[1] && acc1_q != CNT_MAX) acc1_d = acc1_q + 1'b1;
          step_d = step_q + 8'd1;
          if (step_d == len_q) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        count0_d = acc0_q;
        count1_d = acc1_q;
        valid_d  = 1'b1;
        if (acc0_q > acc1_q)      winner_d = WIN_N0;
        else if (acc1_q > acc0_q) winner_d = WIN_N1;
        else                      winner_d = WIN_NONE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= 8'd0;
      step_q   <= 8'd0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      count0_q <= '0;
      count1_q <= '0;
      winner_q <= WIN_NONE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      step_q   <= step_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      winner_q <= winner_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign count0       = count0_q;
  assign count1       = count1_q;
  assign winner       = winner_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spike_rate_classifier.sv
// Scenario bench for spike_rate_classifier: default-width and 4-bit instances
// share stimulus and are compared against a spike-summing reference model.
module tb_spike_rate_classifier;

  logic       system_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       delay_clk;
  logic [1:0] output_spikes;
  logic [7:0] window_len;

  logic [7:0] count0, count1;
  logic [1:0] winner;
  logic       result_valid, busy;

  logic [3:0] count0_4, count1_4;
  logic [1:0] winner_4;
  logic       result_valid_4, busy_4;

  int passed = 0;
  int total  = 0;
  int pulses = 0;
  int pulses4 = 0;

  // Reference model: raw spike sums of the current window.
  int m0, m1;
  logic [17:0] e8;
  logic [9:0]  e4;

  spike_rate_classifier dut (
    .system_clock  (system_clock),
    .reset         (reset),
    .enable        (enable),
    .delay_clk     (delay_clk),
    .output_spikes (output_spikes),
    .window_len    (window_len),
    .count0        (count0),
    .count1        (count1),
    .winner        (winner),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  spike_rate_classifier #(.CNT_BITS(4)) dut4 (
    .system_clock  (system_clock),
    .reset         (reset),
    .enable        (enable),
    .delay_clk     (delay_clk),
    .output_spikes (output_spikes),
    .window_len    (window_len),
    .count0        (count0_4),
    .count1        (count1_4),
    .winner        (winner_4),
    .result_valid  (result_valid_4),
    .busy          (busy_4)
  );

  always #5 system_clock = ~system_clock;

  always @(posedge system_clock) begin
    if (result_valid)   pulses++;
    if (result_valid_4) pulses4++;
  end

  function automatic int sat(input int v, input int bits);
    int mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] win_of(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic expect_result();
    e8 = {8'(sat(m0, 8)), 8'(sat(m1, 8)), win_of(sat(m0, 8), sat(m1, 8))};
    e4 = {4'(sat(m0, 4)), 4'(sat(m1, 4)), win_of(sat(m0, 4), sat(m1, 4))};
  endtask

  task automatic cycle();
    @(posedge system_clock);
    @(negedge system_clock);
  endtask

  task automatic start_window(input logic [7:0] len);
    window_len = len;
    enable     = 1'b1;
    cycle();
    enable     = 1'b0;
    cycle();
    m0 = 0;
    m1 = 0;
  endtask

  // Start edge coincident with a time-step edge carrying spikes on both neurons.
  task automatic start_with_tick(input logic [7:0] len);
    window_len    = len;
    enable        = 1'b1;
    delay_clk     = 1'b1;
    output_spikes = 2'b11;
    cycle();
    enable        = 1'b0;
    delay_clk     = 1'b0;
    cycle();
    m0 = 0;
    m1 = 0;
  endtask

  // One time step; the spike value is only meaningful in the tick cycle.
  task automatic tick(input logic [1:0] s);
    delay_clk     = 1'b1;
    output_spikes = s;
    cycle();
    delay_clk     = 1'b0;
    output_spikes = 2'($urandom);
    m0 += int'(s[0]);
    m1 += int'(s[1]);
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; delay_clk = 1'b0;
    output_spikes = 2'b00; window_len = 8'd0;
    repeat (2) cycle();
    total++;
    if ({count0, count1, winner, result_valid, busy} !== 20'd0)
      $display("FAIL reset_outputs8: got %h expected 0", {count0, count1, winner, result_valid, busy});
    else passed++;
    total++;
    if ({count0_4, count1_4, winner_4, result_valid_4, busy_4} !== 12'd0)
      $display("FAIL reset_outputs4: got %h expected 0", {count0_4, count1_4, winner_4, result_valid_4, busy_4});
    else passed++;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_nominal();
    int p;
    start_window(8'd4);
    total++;
    if (busy !== 1'b1) $display("FAIL nominal_busy: got %b expected 1", busy);
    else passed++;
    tick(2'b01); tick(2'b11); tick(2'b01);
    total++;
    if ({result_valid, busy} !== 2'b01)
      $display("FAIL nominal_pre_final: valid,busy got %b expected 01", {result_valid, busy});
    else passed++;
    p = pulses;
    tick(2'b00);
    expect_result();
    total++;
    if ({result_valid, count0, count1, winner} !== {1'b1, 8'd3, 8'd1, 2'b01})
      $display("FAIL nominal_result: got %h expected %h", {result_valid, count0, count1, winner}, {1'b1, 8'd3, 8'd1, 2'b01});
    else passed++;
    total++;
    if ({count0, count1, winner} !== e8)
      $display("FAIL nominal_model: got %h expected %h", {count0, count1, winner}, e8);
    else passed++;
    cycle();
    total++;
    if ({result_valid, busy} !== 2'b00 || pulses - p != 1)
      $display("FAIL nominal_after: valid,busy %b pulses %0d expected 00 and 1", {result_valid, busy}, pulses - p);
    else passed++;
  endtask

  task automatic test_saturation();
    start_window(8'd20);
    repeat (20) tick(2'b10);
    total++;
    if ({result_valid_4, count0_4, count1_4, winner_4} !== {1'b1, 4'd0, 4'd15, 2'b10})
      $display("FAIL saturation4: got %h expected %h", {result_valid_4, count0_4, count1_4, winner_4}, {1'b1, 4'd0, 4'd15, 2'b10});
    else passed++;
    total++;
    if ({count0, count1, winner} !== {8'd0, 8'd20, 2'b10})
      $display("FAIL saturation8: got %h expected %h", {count0, count1, winner}, {8'd0, 8'd20, 2'b10});
    else passed++;
    cycle();
  endtask

  task automatic test_tie_zero();
    int p;
    start_window(8'd3);
    repeat (3) tick(2'b00);
    total++;
    if ({result_valid, count0, count1, winner} !== {1'b1, 18'd0})
      $display("FAIL tie_result: got %h expected %h", {result_valid, count0, count1, winner}, {1'b1, 18'd0});
    else passed++;
    cycle();
    p = pulses;
    window_len = 8'd0;
    enable = 1'b1;
    cycle();
    total++;
    if (busy !== 1'b0) $display("FAIL zero_len_busy: got %b expected 0", busy);
    else passed++;
    enable = 1'b0;
    tick(2'b11);
    repeat (3) cycle();
    total++;
    if (pulses != p || busy !== 1'b0)
      $display("FAIL zero_len_pulse: pulses %0d busy %b expected 0 and 0", pulses - p, busy);
    else passed++;
  endtask

  task automatic test_restart();
    int p;
    p = pulses;
    start_with_tick(8'd5);
    repeat (3) tick(2'b11);
    start_with_tick(8'd5);
    tick(2'b01); tick(2'b01); tick(2'b10); tick(2'b01);
    total++;
    if (result_valid !== 1'b0) $display("FAIL restart_early: valid got %b expected 0", result_valid);
    else passed++;
    tick(2'b00);
    expect_result();
    total++;
    if ({result_valid, count0, count1, winner} !== {1'b1, e8})
      $display("FAIL restart_result: got %h expected %h", {result_valid, count0, count1, winner}, {1'b1, e8});
    else passed++;
    cycle();
    total++;
    if (pulses - p != 1) $display("FAIL restart_pulses: got %0d expected 1", pulses - p);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int p;
    start_window(8'd6);
    tick(2'b11); tick(2'b11);
    p = pulses;
    reset = 1'b1;
    #1;
    total++;
    if ({count0, count1, winner, result_valid, busy} !== 20'd0)
      $display("FAIL reset_mid8: got %h expected 0", {count0, count1, winner, result_valid, busy});
    else passed++;
    total++;
    if ({count0_4, count1_4, winner_4, result_valid_4, busy_4} !== 12'd0)
      $display("FAIL reset_mid4: got %h expected 0", {count0_4, count1_4, winner_4, result_valid_4, busy_4});
    else passed++;
    window_len = 8'd2;
    enable = 1'b1;
    @(negedge system_clock);
    @(negedge system_clock);
    reset = 1'b0;
    cycle();
    total++;
    if (busy !== 1'b1) $display("FAIL reset_held_enable_start: busy got %b expected 1", busy);
    else passed++;
    enable = 1'b0;
    cycle();
    m0 = 0; m1 = 0;
    tick(2'b10);
    total++;
    if (pulses != p) $display("FAIL reset_mid_pulse: got %0d pulses expected 0", pulses - p);
    else passed++;
    tick(2'b11);
    total++;
    if ({result_valid, count0, count1, winner} !== {1'b1, 8'd1, 8'd2, 2'b10})
      $display("FAIL reset_fresh_result: got %h expected %h", {result_valid, count0, count1, winner}, {1'b1, 8'd1, 8'd2, 2'b10});
    else passed++;
    cycle();
  endtask

  task automatic test_holdover();
    logic [17:0] prev;
    start_window(8'd4);
    tick(2'b10); tick(2'b10); tick(2'b11); tick(2'b01);
    prev = {count0, count1, winner};
    total++;
    if (prev !== {8'd2, 8'd3, 2'b10})
      $display("FAIL holdover_first: got %h expected %h", prev, {8'd2, 8'd3, 2'b10});
    else passed++;
    cycle();
    start_window(8'd4);
    window_len = 8'd9;
    for (int i = 0; i < 3; i++) begin
      tick(2'b11);
      total++;
      if ({result_valid, count0, count1, winner} !== {1'b0, 8'd2, 8'd3, 2'b10})
        $display("FAIL holdover_hold%0d: got %h expected %h", i, {result_valid, count0, count1, winner}, {1'b0, 8'd2, 8'd3, 2'b10});
      else passed++;
    end
    tick(2'b11);
    total++;
    if ({result_valid, count0, count1, winner} !== {1'b1, 8'd4, 8'd4, 2'b00})
      $display("FAIL holdover_latched_len: got %h expected %h", {result_valid, count0, count1, winner}, {1'b1, 8'd4, 8'd4, 2'b00});
    else passed++;
    cycle();
    total++;
    if (busy !== 1'b0) $display("FAIL holdover_busy: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_random();
    int p, p4, len;
    logic [1:0] s;
    for (int w = 0; w < 25; w++) begin
      p  = pulses;
      p4 = pulses4;
      len = $urandom_range(1, 24);
      start_window(8'(len));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          output_spikes = 2'($urandom);
          cycle();
        end
        s[0] = ($urandom_range(0, 9) < 4);
        s[1] = ($urandom_range(0, 9) < 8);
        tick(s);
      end
      expect_result();
      total++;
      if ({result_valid, count0, count1, winner} !== {1'b1, e8})
        $display("FAIL random8_w%0d: got %h expected %h", w, {result_valid, count0, count1, winner}, {1'b1, e8});
      else passed++;
      total++;
      if ({result_valid_4, count0_4, count1_4, winner_4} !== {1'b1, e4})
        $display("FAIL random4_w%0d: got %h expected %h", w, {result_valid_4, count0_4, count1_4, winner_4}, {1'b1, e4});
      else passed++;
      cycle();
      total++;
      if (pulses - p != 1 || pulses4 - p4 != 1 || busy !== 1'b0)
        $display("FAIL random_pulse_w%0d: pulses %0d/%0d busy %b expected 1/1 and 0", w, pulses - p, pulses4 - p4, busy);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_tie_zero();
    test_restart();
    test_reset_mid();
    test_holdover();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spike_rate_classifier.md
SPIKE_RATE_CLASSIFIER -- requirements
Module: spike_rate_classifier

Interface
REQ-001 The block SHALL have one parameter: CNT_BITS, default 8, width of the per-neuron spike counters and count outputs.
REQ-002 The block SHALL have these ports:
- system_clock  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  synchronized level; a rising edge starts a counting window.
- delay_clk  input  1  network time-step clock, produced from system_clock; its rising edges are time steps.
- output_spikes  input  2  output-layer spikes from the SNN core.
- window_len  input  8  window length in time steps.
- count0  output  CNT_BITS  latched spike count, output neuron 0.
- count1  output  CNT_BITS  latched spike count, output neuron 1.
- winner  output  2  01 = neuron 0, 10 = neuron 1, 00 = tie or no spikes.
- result_valid  output  1  one-cycle pulse when new results are latched.
- busy  output  1  high in COUNT and DONE.

Function
REQ-003 Edge detect: enable_q and dclk_q SHALL be registered copies of their inputs. start = enable & ~enable_q. tick = delay_clk & ~dclk_q. Both are combinational.
REQ-004 The FSM SHALL have exactly three states, IDLE, COUNT and DONE, with these transitions:
- IDLE -> COUNT on start with window_len != 0.
- COUNT -> DONE on the tick that makes the step count equal the latched length.
- DONE -> IDLE unconditionally after one cycle.
REQ-005 When start is seen in IDLE with window_len == 0, the block SHALL stay in IDLE and SHALL NOT pulse result_valid.
REQ-006 On entering COUNT, the block SHALL:
- latch window_len into len_r;
- clear acc0, acc1 and step_cnt.
REQ-007 On each tick in COUNT, the block SHALL:
- add output_spikes[i] (sampled in the tick cycle) to acc_i;
- increment step_cnt.
REQ-008 A tick occurring in the same cycle as the start edge SHALL NOT be counted.
REQ-009 acc0 and acc1 SHALL saturate at 2^CNT_BITS-1 and SHALL NOT wrap.
REQ-010 A start during COUNT SHALL restart the window per REQ-006, and the concurrent tick SHALL be discarded. A start during DONE SHALL be ignored.
REQ-011 Changes to window_len after the window starts SHALL NOT affect the current window.
REQ-012 On the edge leaving DONE, the block SHALL:
- load count0 <= acc0 and count1 <= acc1;
- load winner from the comparison of acc0 and acc1;
- set result_valid to 1 for exactly one cycle.
Result: result_valid is high in the second cycle after the final-tick cycle.
REQ-013 count0, count1 and winner SHALL hold their values until the next result load, including while a new window is counting.
REQ-014 winner SHALL be 01 if acc0 > acc1, 10 if acc1 > acc0, and 00 if they are equal (including 0/0).
REQ-015 busy SHALL be registered as state != IDLE.

Reset
REQ-016 Reset SHALL immediately force:
- state to IDLE;
- acc0, acc1, step_cnt, len_r, enable_q and dclk_q to 0;
- count0, count1, winner, result_valid and busy to 0.
REQ-017 A reset mid-window SHALL abandon the window with no result_valid. After release, a new rising edge of enable SHALL be required to start a window; an enable held high through reset counts as a rising edge on the first cycle after release.

Structure
REQ-018 The FSM state encoding and the winner codes (NONE=00, N0=01, N1=10) SHALL live in a shared package, snn_pkg.
REQ-019 The block SHALL instantiate a rising-edge detector sub-module, rise_detect (registered input, pulse output, async reset), twice: once for enable and once for delay_clk.
REQ-020 The saturating counter SHALL be coded inline; the block SHALL have no other sub-modules.

Verification
REQ-021 Nominal: window_len=4, 4 ticks with spikes 01,11,01,00 -> count0=3, count1=1, winner=01, exactly one result_valid pulse, and busy low afterwards.
REQ-022 Saturation: CNT_BITS=4, window_len=20, output_spikes=10 on every tick -> count1=15, count0=0, winner=10.
REQ-023 Tie and zero: window_len=3, no spikes -> count0=count1=0, winner=00, result_valid pulses. window_len=0 with start -> no pulse and busy stays 0.
REQ-024 Restart: window_len=5, start again after 3 ticks -> the counts cover only the 5 ticks after the restart, with a single result_valid pulse.
REQ-025 Reset mid-window: assert reset after 2 of 6 ticks -> all outputs 0 immediately and no result_valid. A fresh start then gives a correct result.
REQ-026 Holdover and length latching: change window_len from 4 to 9 during COUNT -> the window ends after 4 ticks. Previous count0 and count1 stay stable through the next window until its result_valid.
